xbuf_dp_mem: RTL and testbench
==============================

// Module: xbuf_dp_mem
// PURPOSE
//  Parametrised dual-port buffer memory for the XBuffer datapath. It replaces the single-port,
//  both-edge, tristate-data buffer model with separate write and read channels.
//  - Write channel: valid/ready handshake with byte-lane enables.
//  - Read channel: request/response, fixed pipelined latency, credit-based back-pressure.
//  - Out-of-range accesses are flagged.
//  Sits between the host-side transfer engine and the line buffers; positive clock edge only.
// PARAMETERS
//  MEM_WIDTH     256   data word width in bits; multiple of 8, power of two
//  ADDR_WIDTH    32    byte-address width
//  RAM_DEPTH     1024  number of MEM_WIDTH words
//  READ_LATENCY  2     cycles from read accept to rd_rsp_valid; legal 1..4
//  RSP_DEPTH     4     response credits (in-flight + queued reads); must be >= READ_LATENCY
//  derived       BE_W = MEM_WIDTH/8; OFS = log2(BE_W) (5 at default); idx = addr >> OFS
// PORTS
//  clock         in   1           single clock, all state updates on posedge
//  reset         in   1           synchronous, active-high
//  wr_valid      in   1           write request valid
//  wr_ready      out  1           write accepted when wr_valid && wr_ready
//  wr_addr       in   ADDR_WIDTH  byte address; low OFS bits ignored
//  wr_data       in   MEM_WIDTH   write data
//  wr_be         in   BE_W        byte enables; bit i covers wr_data[8i+7:8i]
//  wr_err        out  1           1-cycle pulse: an out-of-range write was dropped
//  rd_req_valid  in   1           read request valid
//  rd_req_ready  out  1           read accepted when rd_req_valid && rd_req_ready
//  rd_addr       in   ADDR_WIDTH  byte address; low OFS bits ignored
//  rd_rsp_valid  out  1           response valid
//  rd_rsp_ready  in   1           response consumed when rd_rsp_valid && rd_rsp_ready
//  rd_rsp_data   out  MEM_WIDTH   read data; 0 whenever rd_rsp_valid=0
//  rd_rsp_err    out  1           response belongs to an out-of-range read; qualified by rd_rsp_valid
// BEHAVIOUR
//  Reset
//  - While reset=1: wr_ready=0, rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0, rd_rsp_err=0, wr_err=0.
//  - Memory array is not reset.
//  Write
//  - wr_ready=1 in every non-reset cycle.
//  - On accept with idx < RAM_DEPTH: only bytes with wr_be=1 are updated at that edge.
//  - On accept with idx >= RAM_DEPTH: array unchanged; wr_err=1 for exactly the following cycle.
//  Read
//  - Credit counter cnt (0..RSP_DEPTH) = in-flight + queued responses.
//  - cnt increments on read accept and decrements on response handshake; both in one cycle -> unchanged.
//  - rd_req_ready = !reset && (cnt < RSP_DEPTH). It is registered-free, i.e. combinational from cnt.
//  - Array is read at the accept edge and the word enters a READ_LATENCY-stage shift pipeline,
//    then a RSP_DEPTH-entry first-word-fall-through FIFO.
//  - Read accepted at edge N with empty FIFO: rd_rsp_valid=1 in the cycle after edge N+READ_LATENCY-1,
//    so READ_LATENCY=1 gives valid the very next cycle.
//  - Back-to-back reads sustain 1/cycle while rd_rsp_ready=1.
//  - Responses are returned strictly in request order; out-of-range reads keep their slot in order.
//  - Out-of-range read (idx >= RAM_DEPTH): data=0, rd_rsp_err=1, same latency.
//  - Stalled head (rd_rsp_valid=1, rd_rsp_ready=0): rd_rsp_data and rd_rsp_err held stable.
//  - FIFO can never overflow, because credits cover the pipeline plus the FIFO.
//  Collision
//  - Write and read accepted at the same edge to the same idx: read returns the new data
//    (write-first, merged per byte enable).
//  - A read already in flight is unaffected by later writes.
//  Reset mid-operation
//  - In-flight and queued responses are discarded; cnt=0.
//  - Outputs are at their reset values in the cycle after the reset edge.
//  - A write presented during reset is dropped.
// TESTING
//  1 Reset, write idx 3 (addr 0x60) all-ones be=all, read 0x60 -> rsp data=all-ones, err=0,
//    rsp valid READ_LATENCY cycles after accept.
//  2 Write 0xAA.. to idx 5, then be=0x0000_000F with data 0x11.. -> read idx 5:
//    low 4 bytes 0x11, rest 0xAA.
//  3 rd_rsp_ready=0, issue reads to idx 0..5 -> exactly 4 accepted (rd_req_ready=0 after);
//    release ready -> 4 rsps in order, then remaining reads accepted.
//  4 Same-cycle write 0x55.. and read, idx 7 -> response 0x55.. (write-first).
//  5 Write addr 1024<<5 -> wr_err pulses 1 cycle, array unchanged;
//    read same addr -> data 0, rd_rsp_err=1, in order between two valid reads.
//  6 Reset asserted with 3 reads queued -> next cycle rd_rsp_valid=0, cnt=0;
//    after release new read returns correct data.

Source files
------------

// File: rtl/xbuf_dp_mem.sv
// Dual-port XBuffer word memory: byte-enabled write channel, pipelined read channel
// with a credit-limited in-order response FIFO and out-of-range flagging.
`timescale 1ns/1ps
module xbuf_dp_mem #(
   parameter int unsigned MEM_WIDTH    = 256,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned RAM_DEPTH    = 1024,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned RSP_DEPTH    = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [ADDR_WIDTH-1:0]    wr_addr,
   input  logic [MEM_WIDTH-1:0]     wr_data,
   input  logic [MEM_WIDTH/8-1:0]   wr_be,
   output logic                     wr_err,
   input  logic                     rd_req_valid,
   output logic                     rd_req_ready,
   input  logic [ADDR_WIDTH-1:0]    rd_addr,
   output logic                     rd_rsp_valid,
   input  logic                     rd_rsp_ready,
   output logic [MEM_WIDTH-1:0]     rd_rsp_data,
   output logic                     rd_rsp_err
);

   localparam int unsigned BE_W   = MEM_WIDTH / 8;
   localparam int unsigned OFS    = $clog2(BE_W);
   localparam int unsigned IDX_W  = ADDR_WIDTH - OFS;
   localparam int unsigned MEM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);

   typedef struct packed {
      logic                 vld;
      logic                 err;
      logic [MEM_WIDTH-1:0] data;
   } rsp_t;

   logic [MEM_WIDTH-1:0] mem_q [RAM_DEPTH];

   logic [IDX_W-1:0]     wr_idx, rd_idx;
   logic [MEM_AW-1:0]    wr_row, rd_row;
   logic                 wr_in_range, rd_in_range;
   logic                 wr_en, rd_acc, rsp_pop;
   logic [MEM_WIDTH-1:0] wr_word_d;
   logic                 wr_err_d, wr_err_q;
   logic [CNT_W-1:0]     cnt_d, cnt_q;
   rsp_t                 rd_stage_c;
   rsp_t                 fifo_in;
   rsp_t                 fifo_d [RSP_DEPTH];
   rsp_t                 fifo_q [RSP_DEPTH];
   logic                 fifo_placed;
   logic                 unused_addr_bits;

   assign unused_addr_bits = ^{wr_addr[OFS-1:0], rd_addr[OFS-1:0]};

   assign wr_idx      = wr_addr[ADDR_WIDTH-1:OFS];
   assign rd_idx      = rd_addr[ADDR_WIDTH-1:OFS];
   assign wr_row      = wr_idx[MEM_AW-1:0];
   assign rd_row      = rd_idx[MEM_AW-1:0];
   assign wr_in_range = (wr_idx < IDX_W'(RAM_DEPTH));
   assign rd_in_range = (rd_idx < IDX_W'(RAM_DEPTH));

   assign wr_ready     = !reset;
   assign rd_req_ready = !reset && (cnt_q < CNT_W'(RSP_DEPTH));
   assign wr_en        = wr_valid && wr_ready && wr_in_range;
   assign wr_err_d     = wr_valid && wr_ready && !wr_in_range;
   assign rd_acc       = rd_req_valid && rd_req_ready;
   assign rsp_pop      = rd_rsp_valid && rd_rsp_ready;

   // Byte-merged write word; also the bypass value for a same-edge read.
   always_comb begin
      wr_word_d = mem_q[wr_row];
      for (int b = 0; b < BE_W; b++) begin
         if (wr_be[b]) wr_word_d[8*b +: 8] = wr_data[8*b +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_row] <= wr_word_d;
   end

   // Word captured at the accept edge; invalid slots carry zero data.
   always_comb begin
      rd_stage_c     = '0;
      rd_stage_c.vld = rd_acc;
      rd_stage_c.err = rd_acc && !rd_in_range;
      if (rd_acc && rd_in_range) begin
         rd_stage_c.data = (wr_en && (wr_row == rd_row)) ? wr_word_d : mem_q[rd_row];
      end
   end

   // The final latency stage is the FIFO write itself, so READ_LATENCY-1 pipe stages.
   generate
      if (READ_LATENCY > 1) begin : g_pipe
         rsp_t pipe_d [READ_LATENCY-1];
         rsp_t pipe_q [READ_LATENCY-1];

         always_comb begin
            pipe_d[0] = rd_stage_c;
            for (int k = 1; k < READ_LATENCY - 1; k++) pipe_d[k] = pipe_q[k-1];
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               for (int k = 0; k < READ_LATENCY - 1; k++) pipe_q[k] <= '0;
            end else begin
               pipe_q <= pipe_d;
            end
         end

         assign fifo_in = pipe_q[READ_LATENCY-2];
      end else begin : g_no_pipe
         assign fifo_in = rd_stage_c;
      end
   endgenerate

   // Shift-down FIFO: entry 0 is the head, pushes land in the first free slot.
   always_comb begin
      fifo_d      = fifo_q;
      fifo_placed = 1'b0;
      if (rsp_pop) begin
         for (int i = 0; i < RSP_DEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
         fifo_d[RSP_DEPTH-1] = '0;
      end
      if (fifo_in.vld) begin
         for (int i = 0; i < RSP_DEPTH; i++) begin
            if (!fifo_placed && !fifo_d[i].vld) begin
               fifo_d[i]   = fifo_in;
               fifo_placed = 1'b1;
            end
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (rd_acc && !rsp_pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!rd_acc && rsp_pop) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q    <= '0;
         wr_err_q <= 1'b0;
         for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         cnt_q    <= cnt_d;
         wr_err_q <= wr_err_d;
         fifo_q   <= fifo_d;
      end
   end

   assign wr_err       = wr_err_q && !reset;
   assign rd_rsp_valid = fifo_q[0].vld && !reset;
   assign rd_rsp_err   = fifo_q[0].err && !reset;
   assign rd_rsp_data  = reset ? '0 : fifo_q[0].data;

endmodule

// File: tb/tb_xbuf_dp_mem.sv
// Scoreboard bench for xbuf_dp_mem: reference memory model feeds an expected-response
// queue, an independent monitor pops and compares on every response handshake.
`timescale 1ns/1ps
module tb_xbuf_dp_mem;

   localparam int unsigned MW    = 256;
   localparam int unsigned AW    = 32;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned RL    = 2;
   localparam int unsigned RD    = 4;
   localparam int unsigned BEW   = MW / 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [AW-1:0] wr_addr = '0;
   logic [MW-1:0] wr_data = '0;
   logic [BEW-1:0] wr_be = '0;
   logic          wr_err;
   logic          rd_req_valid = 1'b0;
   logic          rd_req_ready;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_rsp_valid;
   logic          rd_rsp_ready = 1'b0;
   logic [MW-1:0] rd_rsp_data;
   logic          rd_rsp_err;

   xbuf_dp_mem #(
      .MEM_WIDTH(MW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
      .READ_LATENCY(RL), .RSP_DEPTH(RD)
   ) dut (
      .clock(clock), .reset(reset),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be), .wr_err(wr_err),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
      .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [MW-1:0] data;
      logic          err;
   } exp_t;

   exp_t          exp_q [$];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [MW-1:0] ref_mem [DEPTH];
   int            model_cnt = 0;
   logic          pend_werr = 1'b0;

   task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [MW-1:0] rand_word();
      logic [MW-1:0] w;
      for (int i = 0; i < MW / 32; i++) w[32*i +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      int unsigned r;
      r = $urandom % 16;
      if (r == 0)      return AW'($urandom);
      else if (r == 1) return AW'(((DEPTH + ($urandom % 64)) << 5) | ($urandom % 32));
      else if (r < 7)  return AW'((($urandom % 8) << 5) | ($urandom % 32));
      else             return AW'((($urandom % DEPTH) << 5) | ($urandom % 32));
   endfunction

   // Reference model: byte-lane memory, write applied before a same-edge read.
   logic          m_wacc, m_racc, m_pop;
   logic [AW-1:0] m_widx, m_ridx;
   exp_t          m_e;
   always @(negedge clock) begin
      chk_bit("wr_ready", wr_ready, !reset);
      chk_bit("rd_req_ready", rd_req_ready, !reset && (model_cnt < RD));
      chk_bit("wr_err", wr_err, !reset && pend_werr);
      if (reset) begin
         exp_q.delete();
         model_cnt = 0;
         pend_werr = 1'b0;
      end else begin
         m_wacc = wr_valid && wr_ready;
         m_racc = rd_req_valid && rd_req_ready;
         m_pop  = rd_rsp_valid && rd_rsp_ready;
         m_widx = wr_addr >> 5;
         m_ridx = rd_addr >> 5;
         pend_werr = m_wacc && (m_widx >= DEPTH);
         if (m_wacc && (m_widx < DEPTH)) begin
            for (int b = 0; b < BEW; b++)
               if (wr_be[b]) ref_mem[m_widx[9:0]][8*b +: 8] = wr_data[8*b +: 8];
         end
         if (m_racc) begin
            m_e.err  = (m_ridx >= DEPTH);
            m_e.data = m_e.err ? '0 : ref_mem[m_ridx[9:0]];
            exp_q.push_back(m_e);
         end
         model_cnt = model_cnt + (m_racc ? 1 : 0) - (m_pop ? 1 : 0);
      end
   end

   // Monitor: compares each response handshake against the scoreboard head.
   exp_t          mon_e;
   logic          stall_prev = 1'b0;
   logic [MW-1:0] stall_data;
   logic          stall_err;
   always @(negedge clock) begin
      if (!reset && stall_prev) begin
         chk_bit("stall valid", rd_rsp_valid, 1'b1);
         chk("stall data", rd_rsp_data, stall_data);
         chk_bit("stall err", rd_rsp_err, stall_err);
      end
      if (rd_rsp_valid && rd_rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected response: got data %h with no read outstanding", rd_rsp_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp data", rd_rsp_data, mon_e.data);
            chk_bit("rsp err", rd_rsp_err, mon_e.err);
         end
      end
      if (!rd_rsp_valid) chk("idle data zero", rd_rsp_data, '0);
      stall_prev = rd_rsp_valid && !rd_rsp_ready;
      stall_data = rd_rsp_data;
      stall_err  = rd_rsp_err;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [MW-1:0] d, input logic [BEW-1:0] be);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      wr_be    = be;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int maxw, output bit ok);
      rd_req_valid = 1'b1;
      rd_addr      = a;
      ok           = 1'b0;
      for (int k = 0; k < maxw; k++) begin
         @(negedge clock);
         if (rd_req_ready) begin
            ok = 1'b1;
            step();
            break;
         end
         step();
      end
      rd_req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic [MW-1:0] d, output logic e, output bit ok);
      ok = 1'b0;
      d  = '0;
      e  = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (rd_rsp_valid) begin
            ok = 1'b1;
            d  = rd_rsp_data;
            e  = rd_rsp_err;
            break;
         end
      end
      step();
   endtask

   task automatic drain();
      for (int k = 0; k < 100; k++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      chk_int("drain outstanding", exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit            ok;
      int            acc;
      int            lat;
      logic [MW-1:0] d;
      logic          e;
      logic [MW-1:0] pat;

      repeat (3) step();
      @(negedge clock);
      chk_bit("reset rsp_valid", rd_rsp_valid, 1'b0);
      chk_bit("reset wr_err", wr_err, 1'b0);
      step();
      reset = 1'b0;

      // Fill the whole array so every in-range read has a known value.
      for (int i = 0; i < DEPTH; i++) do_write(AW'(i << 5), rand_word(), '1);

      // 1: write idx 3, read it back, measure latency.
      rd_rsp_ready = 1'b1;
      do_write(32'h60, '1, '1);
      do_read(32'h60, 4, ok);
      chk_bit("t1 read accepted", ok, 1'b1);
      lat = 0;
      while (lat < 20) begin
         @(negedge clock);
         if (rd_rsp_valid) break;
         lat++;
      end
      chk_int("t1 latency", lat + 1, RL);
      chk("t1 data", rd_rsp_data, '1);
      chk_bit("t1 err", rd_rsp_err, 1'b0);
      step();

      // 2: byte-enable merge on idx 5.
      pat = {32{8'hAA}};
      do_write(AW'(5 << 5), pat, '1);
      do_write(AW'(5 << 5), {32{8'h11}}, 32'h0000_000F);
      do_read(AW'(5 << 5), 4, ok);
      wait_rsp(d, e, ok);
      chk_bit("t2 rsp seen", ok, 1'b1);
      chk("t2 merged data", d, {{28{8'hAA}}, {4{8'h11}}});

      // 3: credit back-pressure with the response side stalled.
      rd_rsp_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         do_read(AW'(i << 5), 3, ok);
         if (ok) acc++;
      end
      chk_int("t3 accepted while stalled", acc, RD);
      @(negedge clock);
      chk_bit("t3 ready low", rd_req_ready, 1'b0);
      step();
      rd_rsp_ready = 1'b1;
      do_read(AW'(4 << 5), 10, ok);
      chk_bit("t3 read 4 accepted", ok, 1'b1);
      do_read(AW'(5 << 5), 10, ok);
      chk_bit("t3 read 5 accepted", ok, 1'b1);
      drain();

      // 4: same-edge write and read to idx 7.
      wr_valid = 1'b1; wr_addr = AW'(7 << 5); wr_data = {32{8'h55}}; wr_be = '1;
      rd_req_valid = 1'b1; rd_addr = AW'(7 << 5);
      @(negedge clock);
      chk_bit("t4 read ready", rd_req_ready, 1'b1);
      step();
      wr_valid = 1'b0;
      rd_req_valid = 1'b0;
      wait_rsp(d, e, ok);
      chk_bit("t4 rsp seen", ok, 1'b1);
      chk("t4 write-first data", d, {32{8'h55}});

      // 5: out-of-range write and a read sandwiched between valid reads.
      do_write(AW'(DEPTH << 5), rand_word(), '1);
      @(negedge clock);
      chk_bit("t5 wr_err pulse", wr_err, 1'b1);
      step();
      @(negedge clock);
      chk_bit("t5 wr_err cleared", wr_err, 1'b0);
      step();
      do_read(AW'(1 << 5), 5, ok);
      do_read(AW'(DEPTH << 5), 5, ok);
      chk_bit("t5 oor read accepted", ok, 1'b1);
      do_read(AW'(2 << 5), 5, ok);
      do_read(AW'(0), 5, ok);
      drain();

      // 6: reset with reads queued, then recover.
      rd_rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) do_read(AW'(i << 5), 5, ok);
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clock);
      chk_bit("t6 rsp_valid after reset", rd_rsp_valid, 1'b0);
      chk_bit("t6 credits restored", rd_req_ready, 1'b1);
      step();
      rd_rsp_ready = 1'b1;
      do_read(AW'(7 << 5), 5, ok);
      wait_rsp(d, e, ok);
      chk_bit("t6 rsp seen", ok, 1'b1);
      chk("t6 data after reset", d, {32{8'h55}});

      // Random traffic with occasional resets.
      for (int c = 0; c < 2000; c++) begin
         wr_valid     = 1'($urandom % 2);
         wr_addr      = rand_addr();
         wr_data      = rand_word();
         wr_be        = BEW'($urandom);
         rd_req_valid = (($urandom % 3) != 0);
         rd_addr      = rand_addr();
         rd_rsp_ready = (($urandom % 4) != 0);
         reset        = (($urandom % 400) == 0);
         step();
      end
      wr_valid     = 1'b0;
      rd_req_valid = 1'b0;
      rd_rsp_ready = 1'b1;
      reset        = 1'b0;
      step();
      drain();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
